// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle between N requesters, the shared gate-unit arbiter and the result consumer.
// Requester i's fields are packed at [i*W +: W] for operands and at [i*3 +: 3] for the opcode.
interface gate_unit_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise gate unit among N requesters.
// Flow per operation: IDLE (grant) -> EXEC (compute) -> RESP (hold until accepted).
module gate_unit_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  gate_unit_arbiter_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_reg;
  logic [2:0]         ptr_reg;
  logic [2:0]         id_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [2:0]         op_reg;
  logic               rsp_valid_reg;
  logic [2:0]         rsp_id_reg;
  logic [W-1:0]       rsp_data_reg;
  logic               rsp_err_reg;
  logic               busy_reg;
  logic [CNT_W-1:0]   op_count_reg;

  logic [2*N-1:0]     valid_rot;
  logic               grant_found;
  logic [2:0]         grant_id;
  logic [3:0]         idx_sum;
  logic [3:0]         ptr_sum;
  logic [2:0]         ptr_next;
  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;
  logic [2:0]         sel_op;

  function automatic logic [W-1:0] gate_eval(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [2:0]   op);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~a;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a ^ b;
      3'd6:    r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Rotate so bit k of valid_rot is requester (ptr+k) mod N; the lowest set k wins.
  always_comb begin
    valid_rot   = {bus.req_valid, bus.req_valid} >> ptr_reg;
    grant_found = 1'b0;
    grant_id    = '0;
    idx_sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        idx_sum = 4'(ptr_reg) + 4'(k);
        if (idx_sum >= 4'(N)) begin
          idx_sum = idx_sum - 4'(N);
        end
        grant_found = 1'b1;
        grant_id    = idx_sum[2:0];
      end
    end
  end

  always_comb begin
    ptr_sum  = 4'(grant_id) + 4'd1;
    ptr_next = (ptr_sum == 4'(N)) ? 3'd0 : ptr_sum[2:0];
    sel_a    = W'(bus.req_a >> (32'(grant_id) * W));
    sel_b    = W'(bus.req_b >> (32'(grant_id) * W));
    sel_op   = 3'(bus.req_op >> (32'(grant_id) * 3));
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign bus.req_ready[gi] = (state_reg == IDLE) && grant_found && (grant_id == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            a_reg     <= sel_a;
            b_reg     <= sel_b;
            op_reg    <= sel_op;
            id_reg    <= grant_id;
            ptr_reg   <= ptr_next;
            busy_reg  <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_reg  <= gate_eval(a_reg, b_reg, op_reg);
          rsp_err_reg   <= (op_reg == 3'd7);
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            if (op_count_reg != {CNT_W{1'b1}}) begin
              op_count_reg <= op_count_reg + 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign busy          = busy_reg;
  assign op_count      = op_count_reg;

endmodule
